alu32_arbiter: RTL

Round-robin arbiter and sequencer that shares one 32-bit ALU instance between two requesters, r0 and r1.
It accepts one operation at a time through a valid/ready handshake, registers the operands onto the ALU inputs, and waits a fixed number of ALU_LAT cycles.
It then captures the result and flags and returns them on the winning requester's response channel, holding them until that requester takes them.
It sits between the issue logic and the shared ALU; the ALU is instantiated outside this block.

---
 rtl/alu32_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu32_arbiter.sv
// Round-robin arbiter/sequencer sharing one external 32-bit ALU between two
// requesters. One operation in flight; the result is held on the owner's
// response channel until it is consumed.
module alu32_arbiter #(
  parameter int unsigned ALU_LAT = 1  // cycles ALU inputs are held before sampling (1..15)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  input  logic        r1_valid,
  output logic        r0_ready,
  output logic        r1_ready,
  input  logic [3:0]  r0_sel,
  input  logic [3:0]  r1_sel,
  input  logic [31:0] r0_x,
  input  logic [31:0] r0_y,
  input  logic [31:0] r1_x,
  input  logic [31:0] r1_y,
  output logic        p0_valid,
  output logic        p1_valid,
  input  logic        p0_ready,
  input  logic        p1_ready,
  output logic [31:0] p0_o,
  output logic [31:0] p1_o,
  output logic [3:0]  p0_flags,
  output logic [3:0]  p1_flags,
  output logic        p0_err,
  output logic        p1_err,
  output logic [3:0]  alu_sel,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  input  logic [31:0] alu_o,
  input  logic        alu_v,
  input  logic        alu_z,
  input  logic        alu_s,
  input  logic        alu_c
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(ALU_LAT - 1);
  localparam logic [3:0] SEL_MAX  = 4'd9;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic [1:0]  pvalid_q, pvalid_d;
  logic [1:0]  perr_q, perr_d;
  logic [31:0] po_q [2];
  logic [31:0] po_d [2];
  logic [3:0]  pf_q [2];
  logic [3:0]  pf_d [2];

  logic any_req;
  logic grant;
  logic idle;
  logic own_ready;
  logic illegal;

  // Grant selection: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    any_req   = r0_valid | r1_valid;
    grant     = (r0_valid && r1_valid) ? ~last_q : r1_valid;
    idle      = (state_q == IDLE);
    r0_ready  = idle && any_req && !grant;
    r1_ready  = idle && any_req && grant;
    own_ready = owner_q ? p1_ready : p0_ready;
    illegal   = (sel_q > SEL_MAX);
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    owner_d  = owner_q;
    sel_d    = sel_q;
    x_d      = x_q;
    y_d      = y_q;
    pvalid_d = pvalid_q;
    perr_d   = perr_q;
    po_d     = po_q;
    pf_d     = pf_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d   = grant ? r1_sel : r0_sel;
          x_d     = grant ? r1_x   : r0_x;
          y_d     = grant ? r1_y   : r0_y;
          owner_d = grant;
          last_d  = grant;
          cnt_d   = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          pvalid_d[owner_q] = 1'b1;
          perr_d[owner_q]   = illegal;
          po_d[owner_q]     = illegal ? '0 : alu_o;
          pf_d[owner_q]     = illegal ? '0 : {alu_v, alu_z, alu_s, alu_c};
          state_d           = RESP;
        end
      end
      RESP: begin
        if (own_ready) begin
          pvalid_d[owner_q] = 1'b0;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      sel_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      pvalid_q <= '0;
      perr_q   <= '0;
      po_q[0]  <= '0;
      po_q[1]  <= '0;
      pf_q[0]  <= '0;
      pf_q[1]  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      sel_q    <= sel_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pvalid_q <= pvalid_d;
      perr_q   <= perr_d;
      po_q     <= po_d;
      pf_q     <= pf_d;
    end
  end

  assign alu_sel  = sel_q;
  assign alu_x    = x_q;
  assign alu_y    = y_q;
  assign p0_valid = pvalid_q[0];
  assign p1_valid = pvalid_q[1];
  assign p0_err   = perr_q[0];
  assign p1_err   = perr_q[1];
  assign p0_o     = po_q[0];
  assign p1_o     = po_q[1];
  assign p0_flags = pf_q[0];
  assign p1_flags = pf_q[1];

endmodule
